mux_scan_ctrl: RTL
==================

# mux_scan_ctrl

Sequencer that drives the 4-bit select lines of the 16:1 multiplexer stage and samples its single-bit output. On `start` it walks select indices 0..15, holds each index for a configurable settle time, and captures the mux output into bit `sel` of a 16-bit word. At the end of the sweep it publishes the completed word with a one-cycle `done` pulse. It sits directly around the 16:1 mux: upstream on the select path and downstream on the data path. Together they form a parallel-to-serial-to-parallel scan loop.

## Interface

Parameters:
- `SETTLE_CYC`, default 1: extra cycles each select index is held before sampling. Legal range 0..15.

Ports:
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous reset, active-high
- `start`  in  1  begin a sweep; only honoured in IDLE
- `cont`  in  1  continuous mode; sampled in DONE
- `op_in`  in  1  mux output (`op` of the 16:1 mux)
- `sel`  out  4  select to the mux; `sel[3]`=s3 … `sel[0]`=s0
- `busy`  out  1  high in SETTLE and SAMPLE
- `done`  out  1  one-cycle pulse when `word` updates
- `word`  out  16  last completed sweep; bit i = `op_in` captured at index i

## Operation

- FSM states: IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - `sel`=0, `busy`=0.
  - `start`=1 → SETTLE. Index counter=0, settle counter=SETTLE_CYC, shadow register cleared.
- SETTLE:
  - `sel`=index.
  - Settle counter decrements each cycle; at 0 → SAMPLE.
  - With SETTLE_CYC=0, SETTLE lasts exactly one cycle.
- SAMPLE (one cycle):
  - `shadow[index] <= op_in`.
  - If index=15 → DONE.
  - Else index+1, settle counter reloads SETTLE_CYC → SETTLE.
- DONE (one cycle):
  - `word <= shadow`, `done`=1 in the cycle after the load (registered pulse). `word` and `done` update together.
  - `cont`=1 → SETTLE with index=0 and shadow cleared. Otherwise → IDLE.
- `start` in SETTLE, SAMPLE or DONE: ignored, no restart.
- `start` and `cont` both high in DONE: identical to `cont` alone.
- Index counter is 4 bits. It never wraps inside a sweep because the transition at 15 goes to DONE.
- `word` holds its value between sweeps. A partial sweep never reaches `word`.
- `op_in` is sampled only in SAMPLE. Changes at any other time have no effect.

## Timing

- Each index occupies (SETTLE_CYC+1) SETTLE cycles plus 1 SAMPLE cycle, all with a stable `sel`.
- Sweep length from the `start` edge to the DONE state is 16·(SETTLE_CYC+2) cycles. Default: 48 cycles.
- `done` asserts 1 cycle after DONE and lasts exactly 1 cycle.
- `sel` changes only on the edge leaving SAMPLE.
- `busy` falls on entry to DONE. In continuous mode `busy` is low for exactly 1 cycle between sweeps.
- Reset, including mid-sweep: asynchronous return to IDLE.
  - Outputs: `sel`=0, `busy`=0, `done`=0, `word`=16'h0000.
  - Internal state: shadow cleared, both counters cleared.
- First `start` after reset release is honoured on the first rising edge with `rst` low.

## Structure

- Package `mux_scan_pkg`:
  - State encoding typedef (IDLE/SETTLE/SAMPLE/DONE).
  - Constants `SEL_W`=4 and `N_IN`=16.
- Sub-module `scan_settle_cnt`: loadable down-counter with `load`, `ld_val`, `zero` flag and the same clk/rst. Instantiated once.
- Everything else (FSM, index counter, shadow/word registers) lives in `mux_scan_ctrl`.

## Test plan

- Bench: the real 16:1 mux stage connected between `sel` and `op_in`, with its data inputs driven by the bench.
- Mux data = 16'hA5C3, SETTLE_CYC=1, single `start` → `busy` for 48 cycles, `sel` steps 0..15, one `done` pulse, `word`=16'hA5C3, FSM back in IDLE.
- SETTLE_CYC=0, data = 16'h0001, then 16'h8000 on a second sweep → sweep 32 cycles, `word`=16'h0001 then 16'h8000.
- `cont`=1, data changed from 16'hFFFF to 16'h1234 during the first sweep → first `word` mixes old and new bits exactly per sample times; second `word`=16'h1234; `busy` low for 1 cycle between sweeps.
- `start` pulsed repeatedly mid-sweep → no restart, sweep length unchanged, single `done`.
- `rst` asserted at index 7 after a prior completed sweep of 16'hBEEF → immediate `word`=0, `sel`=0, `busy`=0. Next `start` gives a fresh 48-cycle sweep with the correct `word`.

Source files
------------

// File: rtl/mux_scan_pkg.sv
// mux_scan_pkg: shared state encoding and widths for the mux scan sequencer
package mux_scan_pkg;
  localparam int SEL_W = 4;
  localparam int N_IN = 16;
  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_e;
endpackage

// File: rtl/scan_settle_cnt.sv
// scan_settle_cnt: loadable down-counter that parks at zero
module scan_settle_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] ld_val,
  output logic         zero
);
  logic [W-1:0] cnt_q, cnt_d;
  assign zero = (cnt_q == '0);
  always_comb cnt_d = load ? ld_val : (zero ? cnt_q : cnt_q - 1'b1);
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: sweeps the 16:1 mux selects and assembles the sampled bits into a word
module mux_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter int SETTLE_CYC = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             cont,
  input  logic             op_in,
  output logic [SEL_W-1:0] sel,
  output logic             busy,
  output logic             done,
  output logic [N_IN-1:0]  word
);
  localparam logic [SEL_W-1:0] SETTLE_LD = SEL_W'(SETTLE_CYC);
  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(N_IN - 1);
  state_e state_q, state_d;
  logic [SEL_W-1:0] idx_q, idx_d;
  logic [N_IN-1:0] shadow_q, shadow_d, word_q, word_d;
  logic done_q, load, zero;
  scan_settle_cnt #(.W(SEL_W)) u_settle (
    .clk(clk),
    .rst(rst),
    .load(load),
    .ld_val(SETTLE_LD),
    .zero(zero)
  );
  // The index wraps to 0 when leaving the last SAMPLE, so sel reads 0 in DONE and IDLE.
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    shadow_d = shadow_q;
    word_d = word_q;
    load = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        state_d = SETTLE;
        idx_d = '0;
        shadow_d = '0;
        load = 1'b1;
      end
      SETTLE: state_d = zero ? SAMPLE : SETTLE;
      SAMPLE: begin
        shadow_d[idx_q] = op_in;
        idx_d = idx_q + 1'b1;
        state_d = (idx_q == LAST_IDX) ? DONE : SETTLE;
        load = (idx_q != LAST_IDX);
      end
      DONE: begin
        word_d = shadow_q;
        state_d = cont ? SETTLE : IDLE;
        shadow_d = cont ? '0 : shadow_q;
        load = cont;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      idx_q <= '0;
      shadow_q <= '0;
      word_q <= '0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      shadow_q <= shadow_d;
      word_q <= word_d;
      done_q <= (state_q == DONE);
    end
  assign sel = idx_q;
  assign busy = (state_q == SETTLE) || (state_q == SAMPLE);
  assign done = done_q;
  assign word = word_q;
endmodule
